boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter DATA_W, 16, width of memory words and input stream words.
REQ-002 Parameter ADDR_W, 16, width of memory address.
REQ-003 Parameter BASE_ADDR, 0, first address written by a load.
REQ-004 Parameter MAX_WORDS, 256, maximum image words (checksum excluded), 1..2^ADDR_W.
REQ-005 Parameter RELEASE_DELAY, 4, cycles cpuRst stays high after a good checksum, >=1.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  single-cycle request to begin a load.
REQ-009 inValid  input  1  stream word valid.
REQ-010 inReady  output  1  loader accepts a word this cycle.
REQ-011 inData  input  DATA_W  stream word.
REQ-012 inLast  input  1  marks the final image word (checksum follows).
REQ-013 memWe  output  1  one-cycle RAM write strobe.
REQ-014 memAddr  output  ADDR_W  RAM write address.
REQ-015 memWdata  output  DATA_W  RAM write data.
REQ-016 cpuRst  output  1  active-high CPU reset.
REQ-017 busy, done, error  output  1 each  status flags.
REQ-018 wordCount  output  ADDR_W  image words written in current/last load.

Function
REQ-019 States SHALL be IDLE, LOAD, CHECK, RELEASE, RUN, ERROR.
REQ-020 IDLE: inReady=0, cpuRst=1; start -> LOAD next cycle, address=BASE_ADDR, sum=0, wordCount=0.
REQ-021 Handshake occurs when inValid && inReady in the same cycle; inReady=1 only in LOAD and CHECK.
REQ-022 LOAD handshake: next cycle memWe=1, memAddr=current address, memWdata=inData; address increments modulo 2^ADDR_W; sum += inData modulo 2^DATA_W; wordCount increments.
REQ-023 memWe SHALL be 0 in every cycle not following a LOAD handshake; memAddr/memWdata hold last values.
REQ-024 LOAD handshake with inLast=1 -> CHECK (word still written).
REQ-025 LOAD handshake with inLast=0 when wordCount already equals MAX_WORDS -> ERROR, word not written.
REQ-026 CHECK handshake: word is checksum, never written; equal to sum -> RELEASE, else -> ERROR; inLast ignored.
REQ-027 RELEASE: cpuRst=1 for exactly RELEASE_DELAY cycles, then RUN.
REQ-028 RUN: cpuRst=0, done=1; ERROR: cpuRst=1, error=1.
REQ-029 busy=1 in LOAD, CHECK, RELEASE only.
REQ-030 start in RUN or ERROR -> LOAD next cycle with cpuRst=1 that cycle, flags cleared, counters reinitialised; start in LOAD/CHECK/RELEASE ignored.
REQ-031 Cycles with inValid=0 in LOAD/CHECK SHALL not change state, sum or address.

Reset
REQ-032 rst low SHALL immediately force IDLE, cpuRst=1, memWe=0, inReady=0, busy=done=error=0, memAddr=BASE_ADDR, memWdata=0, wordCount=0, sum=0, regardless of state, including mid-load.
REQ-033 First state change after rst rises SHALL require a start pulse.

Structure
REQ-034 State encoding and default parameter constants SHALL live in shared package rcpu_boot_pkg.
REQ-035 No sub-module; single module with state register, address/count/sum registers and release counter.

Verification
REQ-036 Load 3 words 0x0001,0x0002,0x0003(last), checksum 0x0006 -> writes at 0,1,2, cpuRst falls 4 cycles after checksum accepted, done=1, wordCount=3.
REQ-037 Same image, checksum 0x0007 -> nothing after address 2 written, error=1, cpuRst stays 1.
REQ-038 MAX_WORDS=2, stream 3 words without inLast -> third word not written, error=1.
REQ-039 inValid toggled every other cycle during load -> identical RAM contents and done as REQ-036.
REQ-040 rst low during second word -> cpuRst=1, IDLE, memWe=0; subsequent start and full load succeed from BASE_ADDR.
REQ-041 start in RUN with words 0xFFFF,0x0002(last), checksum 0x0001 -> cpuRst reasserts next cycle, wraparound sum accepted, done=1.

Source files
------------

// File: rtl/rcpu_boot_pkg.sv
// Shared definitions for the boot loader.
// State encoding and default parameter values.
package rcpu_boot_pkg;

   localparam int DEF_DATA_W        = 16;
   localparam int DEF_ADDR_W        = 16;
   localparam int DEF_BASE_ADDR     = 0;
   localparam int DEF_MAX_WORDS     = 256;
   localparam int DEF_RELEASE_DELAY = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CHECK   = 3'd2,
      S_RELEASE = 3'd3,
      S_RUN     = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

endpackage

// File: rtl/boot_loader.sv
// Streams an image into RAM, verifies a trailing checksum,
// then holds the CPU in reset for a fixed delay before releasing it.
module boot_loader
   import rcpu_boot_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int BASE_ADDR     = DEF_BASE_ADDR,
   parameter int MAX_WORDS     = DEF_MAX_WORDS,
   parameter int RELEASE_DELAY = DEF_RELEASE_DELAY
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              inValid,
   output logic              inReady,
   input  logic [DATA_W-1:0] inData,
   input  logic              inLast,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   output logic              cpuRst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] wordCount
);

   // count is one bit wider so MAX_WORDS = 2^ADDR_W is reachable
   localparam int CW = ADDR_W + 1;
   localparam int RW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

   state_t            state;
   state_t            nxt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] sum;
   logic [CW-1:0]     cnt;
   logic [RW-1:0]     relCnt;
   logic              hs;
   logic              full;
   logic              wr;
   logic              init;

   assign hs   = inValid && inReady;
   assign full = (cnt == CW'(MAX_WORDS));
   assign wr   = (state == S_LOAD) && hs && (inLast || !full);
   assign init = start && (state == S_IDLE ||
                           state == S_RUN  ||
                           state == S_ERROR);

   assign wordCount = cnt[ADDR_W-1:0];

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= nxt;
   end

   // next-state selection
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    if (start) nxt = S_LOAD;
         S_LOAD:    if (hs) begin
                       if (inLast)    nxt = S_CHECK;
                       else if (full) nxt = S_ERROR;
                    end
         S_CHECK:   if (hs) nxt = (inData == sum) ? S_RELEASE : S_ERROR;
         S_RELEASE: if (relCnt == RW'(RELEASE_DELAY - 1)) nxt = S_RUN;
         S_RUN:     if (start) nxt = S_LOAD;
         S_ERROR:   if (start) nxt = S_LOAD;
         default:   nxt = S_IDLE;
      endcase
   end

   // status outputs decoded from state
   always_comb begin
      inReady = 1'b0;
      cpuRst  = 1'b1;
      busy    = 1'b0;
      done    = 1'b0;
      error   = 1'b0;
      case (state)
         S_LOAD:    begin inReady = 1'b1; busy = 1'b1; end
         S_CHECK:   begin inReady = 1'b1; busy = 1'b1; end
         S_RELEASE: busy = 1'b1;
         S_RUN:     begin cpuRst = 1'b0; done = 1'b1; end
         S_ERROR:   error = 1'b1;
         default:   ;
      endcase
   end

   // address, sum, count and RAM write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr     <= ADDR_W'(BASE_ADDR);
         sum      <= '0;
         cnt      <= '0;
         memWe    <= 1'b0;
         memAddr  <= ADDR_W'(BASE_ADDR);
         memWdata <= '0;
      end else begin
         memWe <= wr;
         if (init) begin
            addr <= ADDR_W'(BASE_ADDR);
            sum  <= '0;
            cnt  <= '0;
         end else if (wr) begin
            memAddr  <= addr;
            memWdata <= inData;
            addr     <= addr + ADDR_W'(1);
            sum      <= sum + inData;
            cnt      <= cnt + CW'(1);
         end
      end
   end

   // cycles spent in release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    relCnt <= '0;
      else if (state == S_RELEASE) relCnt <= relCnt + RW'(1);
      else                         relCnt <= '0;
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a cycle model.
// A second instance with MAX_WORDS=2 covers overflow.
module tb_boot_loader;

   localparam int MAXW = 256;
   localparam int RD   = 4;
   localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2;
   localparam int P_REL  = 3, P_RUN  = 4, P_ERR   = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start = 1'b0;
   logic        inValid = 1'b0;
   logic [15:0] inData = '0;
   logic        inLast = 1'b0;
   logic        inReady, memWe, cpuRst, busy, done, error;
   logic [15:0] memAddr, memWdata, wordCount;
   logic        inReady2, memWe2, cpuRst2, busy2, done2, error2;
   logic [15:0] memAddr2, memWdata2, wordCount2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   boot_loader #(.MAX_WORDS(MAXW), .RELEASE_DELAY(RD)) dut (
      .clk(clk), .rst(rst), .start(start),
      .inValid(inValid), .inReady(inReady),
      .inData(inData), .inLast(inLast),
      .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .cpuRst(cpuRst), .busy(busy), .done(done), .error(error),
      .wordCount(wordCount));

   boot_loader #(.MAX_WORDS(2), .RELEASE_DELAY(RD)) dut2 (
      .clk(clk), .rst(rst), .start(start),
      .inValid(inValid), .inReady(inReady2),
      .inData(inData), .inLast(inLast),
      .memWe(memWe2), .memAddr(memAddr2), .memWdata(memWdata2),
      .cpuRst(cpuRst2), .busy(busy2), .done(done2), .error(error2),
      .wordCount(wordCount2));

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model: phase, running sum, count, write port
   int          m_ph;
   int          m_rel;
   int          m_cnt;
   logic [15:0] m_addr, m_sum, m_maddr, m_wdata;
   logic        m_we;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ph <= P_IDLE; m_rel <= 0; m_cnt <= 0;
         m_addr <= 0; m_sum <= 0; m_we <= 0;
         m_maddr <= 0; m_wdata <= 0;
      end else begin
         m_we <= 1'b0;
         if (m_ph == P_IDLE || m_ph == P_RUN || m_ph == P_ERR) begin
            if (start) begin
               m_ph <= P_LOAD; m_addr <= 0; m_sum <= 0; m_cnt <= 0;
            end
         end else if (m_ph == P_LOAD) begin
            if (inValid) begin
               if (inLast || m_cnt != MAXW) begin
                  m_we <= 1'b1; m_maddr <= m_addr; m_wdata <= inData;
                  m_addr <= m_addr + 16'd1;
                  m_sum <= m_sum + inData;
                  m_cnt <= m_cnt + 1;
                  if (inLast) m_ph <= P_CHECK;
               end else m_ph <= P_ERR;
            end
         end else if (m_ph == P_CHECK) begin
            if (inValid) begin
               m_ph <= (inData == m_sum) ? P_REL : P_ERR;
               m_rel <= RD;
            end
         end else if (m_ph == P_REL) begin
            m_rel <= m_rel - 1;
            if (m_rel == 1) m_ph <= P_RUN;
         end
      end
   end

   // RAM write logs of both instances
   logic [15:0] dmem [16];
   int nwr = 0, nwr2 = 0;
   logic [15:0] lastAddr2;

   // per-cycle compare against the model
   always @(posedge clk) begin
      #1;
      chk("cpuRst", cpuRst, m_ph != P_RUN);
      chk("inReady", inReady, m_ph == P_LOAD || m_ph == P_CHECK);
      chk("busy", busy, m_ph == P_LOAD || m_ph == P_CHECK || m_ph == P_REL);
      chk("done", done, m_ph == P_RUN);
      chk("error", error, m_ph == P_ERR);
      chk("memWe", memWe, m_we);
      chk("memAddr", memAddr, m_maddr);
      chk("memWdata", memWdata, m_wdata);
      chk("wordCount", wordCount, m_cnt[15:0]);
      if (memWe) begin
         dmem[memAddr[3:0]] = memWdata;
         nwr++;
      end
      if (memWe2) begin
         nwr2++;
         lastAddr2 = memAddr2;
      end
   end

   task automatic send(input logic [15:0] d, input logic l);
      inValid = 1'b1; inData = d; inLast = l;
      @(negedge clk);
      inValid = 1'b0; inLast = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(output int n);
      n = 0;
      while (cpuRst && !error && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         errors++;
         $display("FAIL timeout: got busy %0d want done", busy);
      end
   endtask

   int n, w0;

   initial begin
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cpuRst", cpuRst, 1);
      chk("rst_memAddr", memAddr, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_start", busy, 0);

      // good 3-word image
      pulse_start();
      send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 1);
      send(16'h0006, 0);
      wait_end(n);
      chk("A_release_cycles", n, 4);
      chk("A_done", done, 1);
      chk("A_count", wordCount, 3);
      chk("A_mem2", dmem[2], 16'h0003);
      chk("A_nwr", nwr, 3);

      // bad checksum
      w0 = nwr;
      pulse_start();
      send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 1);
      send(16'h0007, 0);
      repeat (3) @(negedge clk);
      chk("B_error", error, 1);
      chk("B_cpuRst", cpuRst, 1);
      chk("B_writes", nwr - w0, 3);

      // gapped valid
      dmem[0] = 0; dmem[1] = 0; dmem[2] = 0;
      pulse_start();
      send(16'h0001, 0); @(negedge clk);
      send(16'h0002, 0); @(negedge clk);
      send(16'h0003, 1); @(negedge clk);
      send(16'h0006, 0);
      wait_end(n);
      chk("C_done", done, 1);
      chk("C_mem0", dmem[0], 16'h0001);
      chk("C_mem1", dmem[1], 16'h0002);

      // reset during second word
      pulse_start();
      send(16'h0001, 0);
      inValid = 1'b1; inData = 16'h0002;
      #2 rst = 1'b0;
      #1;
      chk("D_cpuRst", cpuRst, 1);
      chk("D_memWe", memWe, 0);
      chk("D_inReady", inReady, 0);
      inValid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("D_stay_idle", busy, 0);
      pulse_start();
      send(16'h0004, 0); send(16'h0005, 1); send(16'h0009, 0);
      wait_end(n);
      chk("D_done", done, 1);
      chk("D_mem0", dmem[0], 16'h0004);

      // restart from RUN with wraparound sum
      pulse_start();
      chk("E_cpuRst_reassert", cpuRst, 1);
      send(16'hFFFF, 0); send(16'h0002, 1); send(16'h0001, 0);
      wait_end(n);
      chk("E_done", done, 1);
      chk("E_count", wordCount, 2);

      // overflow on MAX_WORDS=2 instance
      w0 = nwr2;
      pulse_start();
      send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 0);
      repeat (2) @(negedge clk);
      chk("F_writes", nwr2 - w0, 2);
      chk("F_lastAddr", lastAddr2, 1);
      chk("F_error", error2, 1);
      chk("F_count", wordCount2, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
